row_window_buffer: RTL and testbench
====================================

// Module: row_window_buffer
// PURPOSE
//   Parametrised multi-row register bank; successor to the single-word DFF.
//   Holds DEPTH rows of WIDTH cells of the Conway grid.
//   Presents a registered 3-row window (above/current/below) around a row pointer
//   to the cell-update logic, with toroidal wrap at the top and bottom rows.
//   Rows are loaded by addressed writes; the pointer advances one row per request.
// PARAMETERS
//   WIDTH   11               cells per row (bits per stored word)
//   DEPTH   8                number of rows; legal range DEPTH >= 3, need not be 2^n
//   ADDR_W  $clog2(DEPTH)    row address / pointer width (derived; do not override)
// PORTS
//   clk        in   1       clock, all state updates on rising edge
//   reset      in   1       synchronous, active-high reset
//   we         in   1       write enable for d -> row waddr
//   waddr      in   ADDR_W  row address of write
//   d          in   WIDTH   write data
//   advance    in   1       move pointer to next row (wraps DEPTH-1 -> 0)
//   clr        in   1       synchronous clear of all rows and the pointer
//   row_above  out  WIDTH   contents of row (ptr-1) mod DEPTH
//   row_cur    out  WIDTH   contents of row ptr
//   row_below  out  WIDTH   contents of row (ptr+1) mod DEPTH
//   ptr        out  ADDR_W  current row pointer
//   wrap       out  1       1-cycle pulse: the pointer wrapped DEPTH-1 -> 0 on this edge
//   werr       out  1       1-cycle pulse: write rejected, waddr >= DEPTH
// BEHAVIOUR
// - Reset (on the clk edge with reset=1): all rows = 0, ptr = 0, and every output = 0.
//   - Reset overrides all other inputs, including reset asserted mid-operation.
// - Priority: reset > clr > {we, advance}.
//   - clr zeroes all rows and ptr; wrap = 0 and werr = 0.
//   - we and advance are ignored on the clr edge.
// - Write:
//   - On an edge with we=1 and waddr < DEPTH: mem[waddr] <= d.
//   - we=1 and waddr >= DEPTH: memory unchanged and werr = 1 for that cycle.
//   - we=0: memory holds, including when d changes.
// - Advance:
//   - ptr <= (ptr == DEPTH-1) ? 0 : ptr+1.
//   - wrap = 1 only on the edge where ptr goes DEPTH-1 -> 0, else 0.
// - Window outputs are registered. They always reflect the post-edge state: new ptr and new memory.
//   - A write to any row in the window appears on the outputs after the same edge (write-through).
//   - Simultaneous we + advance: the write lands first, then the window is taken at the new ptr.
//     A write to the row entering the window is visible immediately.
// - Toroidal boundaries:
//   - ptr = 0: row_above = mem[DEPTH-1].
//   - ptr = DEPTH-1: row_below = mem[0].
// - Latency: one edge from input to output for all ports. No combinational input->output paths.
// - With we=0, advance=0 and clr=0, every output holds its value indefinitely.
// TESTING  (WIDTH=11, DEPTH=5 unless noted)
// 1. Reset: reset=1 for 1 edge -> all outputs 0. Then d=11'h7FF, we=0 for 20 clocks -> row_cur=0, ptr=0.
// 2. Load and window:
//    - Write rows 0..4 = 11'h001, 002, 004, 008, 010.
//    - Result with ptr=0: above=010, cur=001, below=002.
//    - Advance 4 times: ptr=4, above=008, cur=010, below=001.
// 3. Wrap: from ptr=4, advance once -> ptr=0 and wrap=1 for exactly 1 cycle, then 0. 4 more advances -> no wrap pulse.
// 4. Simultaneous write + advance:
//    - Initial state: ptr=1.
//    - Stimulus on one edge: we=1, waddr=3, d=11'h5A5, advance=1.
//    - Result on the same edge: ptr=2, row_below=5A5.
// 5. Bad address: we=1, waddr=5 (also 7), d=11'h3FF -> werr=1 for 1 cycle, all rows unchanged.
// 6. Clear and reset:
//    - clr=1 with we=1, waddr=0, d=11'h0FF -> all rows 0, ptr=0, row 0 stays 0.
//    - reset=1 with advance=1 mid-scan -> ptr=0, outputs 0.
//    - Repeat with DEPTH=8 to cover the 2^n case.

Source files
------------

// File: rtl/row_window_if.sv
// ---------------------------------------------------------------------------
// row_window_if
//   Bundles the write/advance/clear controls and the registered 3-row window
//   outputs of row_window_buffer.
//
//   Parameters
//     WIDTH   cells per row
//     DEPTH   number of rows
//     ADDR_W  row address / pointer width (derived from DEPTH)
//
//   Signals (direction as seen by the buffer, i.e. the slave modport)
//     we         in   write enable for d -> row waddr
//     waddr      in   row address of the write
//     d          in   write data
//     advance    in   move pointer to the next row (toroidal)
//     clr        in   synchronous clear of all rows and the pointer
//     row_above  out  row (ptr-1) mod DEPTH
//     row_cur    out  row ptr
//     row_below  out  row (ptr+1) mod DEPTH
//     ptr        out  current row pointer
//     wrap       out  1-cycle pulse when the pointer wraps DEPTH-1 -> 0
//     werr       out  1-cycle pulse when a write is rejected (waddr >= DEPTH)
// ---------------------------------------------------------------------------
interface row_window_if #(
    parameter int WIDTH  = 11,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  d;
    logic              advance;
    logic              clr;
    logic [WIDTH-1:0]  row_above;
    logic [WIDTH-1:0]  row_cur;
    logic [WIDTH-1:0]  row_below;
    logic [ADDR_W-1:0] ptr;
    logic              wrap;
    logic              werr;

    // Control side: drives writes and pointer movement, consumes the window.
    modport master (
        output we, waddr, d, advance, clr,
        input  row_above, row_cur, row_below, ptr, wrap, werr
    );

    // Buffer side.
    modport slave (
        input  we, waddr, d, advance, clr,
        output row_above, row_cur, row_below, ptr, wrap, werr
    );
endinterface

// File: rtl/row_window_buffer.sv
// ---------------------------------------------------------------------------
// row_window_buffer
//   Multi-row register bank holding DEPTH rows of WIDTH Conway-grid cells.
//   Presents a registered 3-row window (above / current / below) around a
//   row pointer, with toroidal wrap at the top and bottom rows.
//
//   Parameters
//     WIDTH   cells per row (bits per stored word)
//     DEPTH   number of rows, DEPTH >= 3, need not be a power of two
//     ADDR_W  row address / pointer width, derived from DEPTH
//
//   Ports
//     clk     in   rising-edge clock for all state
//     reset   in   synchronous active-high reset; zeroes rows, pointer and
//                  every output, overriding all other inputs
//     bus     row_window_if.slave
//               we/waddr/d : addressed row write
//               advance    : pointer step with wrap DEPTH-1 -> 0
//               clr        : synchronous clear of rows and pointer
//               row_above/row_cur/row_below/ptr : registered window
//               wrap/werr  : 1-cycle status pulses
//
//   Priority on a clock edge: reset > clr > {we, advance}.
//   The window registers are loaded from the *next* memory image at the
//   *next* pointer, so a write or an advance is visible on the outputs after
//   the very edge on which it happens (write-through, one-edge latency).
// ---------------------------------------------------------------------------
module row_window_buffer #(
    parameter int WIDTH  = 11,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    row_window_if.slave  bus
);

    typedef logic [WIDTH-1:0] row_t;

    localparam logic [ADDR_W-1:0] ZERO_PTR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);
    localparam row_t              ZERO_ROW = {WIDTH{1'b0}};

    // ------------------------------------------------------------------
    // Toroidal pointer arithmetic. DEPTH need not be a power of two, so
    // the wrap points are explicit rather than relying on overflow.
    // ------------------------------------------------------------------
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        if (p == LAST_ROW) begin
            ptr_inc = ZERO_PTR;
        end else begin
            ptr_inc = p + ADDR_W'(1);
        end
    endfunction

    function automatic logic [ADDR_W-1:0] ptr_dec(input logic [ADDR_W-1:0] p);
        if (p == ZERO_PTR) begin
            ptr_dec = LAST_ROW;
        end else begin
            ptr_dec = p - ADDR_W'(1);
        end
    endfunction

    // Storage and pointer state
    row_t              mem_r      [DEPTH];
    logic [ADDR_W-1:0] ptr_r;

    // Registered outputs
    row_t              above_r;
    row_t              cur_r;
    row_t              below_r;
    logic              wrap_r;
    logic              werr_r;

    // Next-state image
    row_t              mem_next_s [DEPTH];
    logic [ADDR_W-1:0] ptr_next_s;
    logic              wrap_next_s;
    logic              werr_next_s;
    row_t              above_next_s;
    row_t              cur_next_s;
    row_t              below_next_s;
    logic              waddr_ok_s;

    // ------------------------------------------------------------------
    // Address range check. When DEPTH fills the address space every code
    // is a legal row; otherwise codes above the last row are rejected.
    // ------------------------------------------------------------------
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_range
            assign waddr_ok_s = 1'b1;
        end else begin : g_partial_range
            assign waddr_ok_s = (bus.waddr <= LAST_ROW);
        end
    endgenerate

    // Next memory image, pointer and status pulses from clr / we / advance.
    always_comb begin
        mem_next_s  = mem_r;
        ptr_next_s  = ptr_r;
        wrap_next_s = 1'b0;
        werr_next_s = 1'b0;

        if (bus.clr) begin
            // clr masks any write or advance on the same edge
            for (int i = 0; i < DEPTH; i++) begin
                mem_next_s[i] = ZERO_ROW;
            end
            ptr_next_s = ZERO_PTR;
        end else begin
            if (bus.we) begin
                if (waddr_ok_s) begin
                    mem_next_s[bus.waddr] = bus.d;
                end else begin
                    werr_next_s = 1'b1;
                end
            end else begin
                werr_next_s = 1'b0;
            end

            if (bus.advance) begin
                ptr_next_s  = ptr_inc(ptr_r);
                wrap_next_s = (ptr_r == LAST_ROW);
            end else begin
                ptr_next_s  = ptr_r;
            end
        end
    end

    // Window taken from the post-edge memory at the post-edge pointer, so a
    // row written while it enters the window is seen immediately.
    always_comb begin
        above_next_s = mem_next_s[ptr_dec(ptr_next_s)];
        cur_next_s   = mem_next_s[ptr_next_s];
        below_next_s = mem_next_s[ptr_inc(ptr_next_s)];
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ZERO_ROW;
            end
            ptr_r   <= ZERO_PTR;
            above_r <= ZERO_ROW;
            cur_r   <= ZERO_ROW;
            below_r <= ZERO_ROW;
            wrap_r  <= 1'b0;
            werr_r  <= 1'b0;
        end else begin
            mem_r   <= mem_next_s;
            ptr_r   <= ptr_next_s;
            above_r <= above_next_s;
            cur_r   <= cur_next_s;
            below_r <= below_next_s;
            wrap_r  <= wrap_next_s;
            werr_r  <= werr_next_s;
        end
    end

    assign bus.row_above = above_r;
    assign bus.row_cur   = cur_r;
    assign bus.row_below = below_r;
    assign bus.ptr       = ptr_r;
    assign bus.wrap      = wrap_r;
    assign bus.werr      = werr_r;

endmodule

// File: tb/tb_row_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_row_window_buffer
//   Drives a DEPTH=5 and a DEPTH=8 instance (WIDTH=11) with identical
//   stimulus and checks both against a behavioural model of the row bank,
//   plus directed expected values for the DEPTH=5 scenarios.
//   Output vector layout: {above[37:27], cur[26:16], below[15:5],
//   ptr[4:2], wrap[1], werr[0]}.
// ---------------------------------------------------------------------------
module tb_row_window_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic        advance;
    logic        clr;
    logic [2:0]  waddr;
    logic [10:0] d;

    always #5 clk = ~clk;

    row_window_if #(.WIDTH(11), .DEPTH(5)) if5 ();
    row_window_if #(.WIDTH(11), .DEPTH(8)) if8 ();

    assign if5.we = we;  assign if5.waddr = waddr;  assign if5.d = d;
    assign if5.advance = advance;  assign if5.clr = clr;
    assign if8.we = we;  assign if8.waddr = waddr;  assign if8.d = d;
    assign if8.advance = advance;  assign if8.clr = clr;

    row_window_buffer #(.WIDTH(11), .DEPTH(5)) dut5 (.clk(clk), .reset(reset), .bus(if5));
    row_window_buffer #(.WIDTH(11), .DEPTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

    // ---------------- behavioural model ----------------
    int          dep [2] = '{5, 8};
    logic [10:0] mm  [2][8];
    int          pp  [2];
    logic        ewrap [2];
    logic        ewerr [2];

    int checks = 0;
    int errors = 0;

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (reset || clr) begin
                for (int r = 0; r < 8; r++) mm[k][r] = 11'h000;
                pp[k]    = 0;
                ewrap[k] = 1'b0;
                ewerr[k] = 1'b0;
            end else begin
                ewerr[k] = we && (int'(waddr) >= dep[k]);
                if (we && int'(waddr) < dep[k]) mm[k][waddr] = d;
                ewrap[k] = advance && (pp[k] == dep[k] - 1);
                if (advance) pp[k] = (pp[k] + 1) % dep[k];
            end
        end
    endtask

    function automatic logic [37:0] exp_vec(int k);
        int p;
        int n;
        p = pp[k];
        n = dep[k];
        return {mm[k][(p + n - 1) % n], mm[k][p], mm[k][(p + 1) % n],
                3'(p), ewrap[k], ewerr[k]};
    endfunction

    function automatic logic [37:0] obs_vec(int k);
        if (k == 0)
            return {if5.row_above, if5.row_cur, if5.row_below, if5.ptr, if5.wrap, if5.werr};
        else
            return {if8.row_above, if8.row_cur, if8.row_below, if8.ptr, if8.wrap, if8.werr};
    endfunction

    // one clock edge, model update, then settle past the edge
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; we = 1'b0; advance = 1'b0; clr = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [37:0] ov;
        logic [37:0] ev;
        reset = 1'b1; we = 1'b1; advance = 1'b1; clr = 1'b0;
        waddr = 3'd2; d = 11'($urandom);
        step();
        for (int k = 0; k < 2; k++) begin
            ov = obs_vec(k);
            checks++;
            if (ov !== 38'h0) begin
                errors++;
                $display("FAIL reset_outputs [D=%0d] got=%h expected=%h", dep[k], ov, 38'h0);
            end
        end
        idle();
        d = 11'h7FF;
        for (int c = 0; c < 20; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                ov = obs_vec(k);
                ev = exp_vec(k);
                checks++;
                if (ov !== ev || ov[26:16] !== 11'h000 || ov[4:2] !== 3'd0) begin
                    errors++;
                    $display("FAIL reset_hold [D=%0d] got=%h expected=%h", dep[k], ov, ev);
                end
            end
        end
    endtask

    task automatic test_load_window();
        logic [37:0] ov;
        logic [37:0] ev;
        idle();
        for (int i = 0; i < 5; i++) begin
            we = 1'b1; waddr = 3'(i); d = 11'(1 << i);
            step();
            for (int k = 0; k < 2; k++) begin
                ov = obs_vec(k); ev = exp_vec(k);
                checks++;
                if (ov !== ev) begin
                    errors++;
                    $display("FAIL load [D=%0d] got=%h expected=%h", dep[k], ov, ev);
                end
            end
        end
        we = 1'b0;
        ov = obs_vec(0);
        checks++;
        if (ov !== {11'h010, 11'h001, 11'h002, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL window_ptr0 got=%h expected=%h", ov, {11'h010, 11'h001, 11'h002, 3'd0, 2'b00});
        end
        advance = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                ov = obs_vec(k); ev = exp_vec(k);
                checks++;
                if (ov !== ev) begin
                    errors++;
                    $display("FAIL advance [D=%0d] got=%h expected=%h", dep[k], ov, ev);
                end
            end
        end
        advance = 1'b0;
        ov = obs_vec(0);
        checks++;
        if (ov !== {11'h008, 11'h010, 11'h001, 3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL window_ptr4 got=%h expected=%h", ov, {11'h008, 11'h010, 11'h001, 3'd4, 2'b00});
        end
    endtask

    task automatic test_wrap();
        logic [37:0] ov;
        logic [37:0] ev;
        idle();
        advance = 1'b1;
        step();
        advance = 1'b0;
        ov = obs_vec(0);
        checks++;
        if (ov !== {11'h010, 11'h001, 11'h002, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_pulse got=%h expected=%h", ov, {11'h010, 11'h001, 11'h002, 3'd0, 2'b10});
        end
        step();
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 2; k++) begin
                ov = obs_vec(k); ev = exp_vec(k);
                checks++;
                if (ov !== ev || (k == 0 && ov[1] !== 1'b0)) begin
                    errors++;
                    $display("FAIL wrap_after [D=%0d] got=%h expected=%h", dep[k], ov, ev);
                end
            end
            advance = 1'b1;
            if (i < 4) step();
        end
        advance = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [37:0] ov;
        logic [37:0] ev;
        idle();
        advance = 1'b1;
        step();
        step();
        checks++;
        if (if5.ptr !== 3'd1) begin
            errors++;
            $display("FAIL simul_setup got=%0d expected=%0d", if5.ptr, 1);
        end
        we = 1'b1; waddr = 3'd3; d = 11'h5A5; advance = 1'b1;
        step();
        idle();
        ov = obs_vec(0);
        checks++;
        if (ov[4:2] !== 3'd2 || ov[15:5] !== 11'h5A5) begin
            errors++;
            $display("FAIL simul_write_adv got ptr=%0d below=%h expected ptr=2 below=5a5", ov[4:2], ov[15:5]);
        end
        for (int k = 0; k < 2; k++) begin
            ov = obs_vec(k); ev = exp_vec(k);
            checks++;
            if (ov !== ev) begin
                errors++;
                $display("FAIL simul_model [D=%0d] got=%h expected=%h", dep[k], ov, ev);
            end
        end
    endtask

    task automatic test_bad_addr();
        logic [37:0] ov;
        logic [37:0] ev;
        logic [2:0]  bad [2] = '{3'd5, 3'd7};
        idle();
        for (int j = 0; j < 2; j++) begin
            we = 1'b1; waddr = bad[j]; d = 11'h3FF;
            step();
            we = 1'b0;
            checks++;
            if (if5.werr !== 1'b1) begin
                errors++;
                $display("FAIL werr_pulse addr=%0d got=%b expected=1", bad[j], if5.werr);
            end
            step();
            checks++;
            if (if5.werr !== 1'b0) begin
                errors++;
                $display("FAIL werr_clear got=%b expected=0", if5.werr);
            end
        end
        advance = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                ov = obs_vec(k); ev = exp_vec(k);
                checks++;
                if (ov !== ev) begin
                    errors++;
                    $display("FAIL bad_addr_scan [D=%0d] got=%h expected=%h", dep[k], ov, ev);
                end
            end
        end
        advance = 1'b0;
    endtask

    task automatic test_clear();
        logic [37:0] ov;
        logic [37:0] ev;
        idle();
        clr = 1'b1; we = 1'b1; waddr = 3'd0; d = 11'h0FF; advance = 1'b1;
        step();
        clr = 1'b0; we = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ov = obs_vec(k);
            checks++;
            if (ov !== 38'h0) begin
                errors++;
                $display("FAIL clr_outputs [D=%0d] got=%h expected=%h", dep[k], ov, 38'h0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                ov = obs_vec(k); ev = exp_vec(k);
                checks++;
                if (ov !== ev || ov[37:5] !== 33'h0) begin
                    errors++;
                    $display("FAIL clr_scan [D=%0d] got=%h expected=%h", dep[k], ov, ev);
                end
            end
        end
        advance = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [37:0] ov;
        idle();
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); d = 11'($urandom); advance = (i % 3 == 0);
            step();
        end
        idle();
        reset = 1'b1; advance = 1'b1;
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            ov = obs_vec(k);
            checks++;
            if (ov !== 38'h0) begin
                errors++;
                $display("FAIL reset_mid [D=%0d] got=%h expected=%h", dep[k], ov, 38'h0);
            end
        end
    endtask

    task automatic test_random();
        logic [37:0] ov;
        logic [37:0] ev;
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom % 64 == 0);
            clr     = ($urandom % 32 == 0);
            we      = 1'($urandom);
            advance = 1'($urandom);
            waddr   = 3'($urandom);
            d       = 11'($urandom);
            step();
            for (int k = 0; k < 2; k++) begin
                ov = obs_vec(k); ev = exp_vec(k);
                checks++;
                if (ov !== ev) begin
                    errors++;
                    $display("FAIL random c=%0d [D=%0d] got=%h expected=%h", c, dep[k], ov, ev);
                end
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; advance = 1'b0; clr = 1'b0;
        waddr = 3'd0; d = 11'h000;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 8; r++) mm[k][r] = 11'h000;
            pp[k] = 0; ewrap[k] = 1'b0; ewerr[k] = 1'b0;
        end
        test_reset();
        test_load_window();
        test_wrap();
        test_back_to_back();
        test_bad_addr();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
